// File: rtl/m_countdown_timer.sv
// Loadable down-counter: counts a reload value to zero on enabled cycles and pulses tc at the terminal count.
// Latency: q, tc, busy and done all change one ck edge after the causing input.
// Backpressure: none; load, stop and start act on the edge where they are sampled, in that priority order.
module m_countdown_timer #(
  parameter int WIDTH = 4
) (
  input  logic             ck,
  input  logic             nres,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  input  logic             start,
  input  logic             stop,
  input  logic             en,
  input  logic             auto_reload,
  output logic [WIDTH-1:0] q,
  output logic             busy,
  output logic             tc,
  output logic             done
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0] CNT_ZERO = '0;
  localparam logic [WIDTH-1:0] CNT_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

  state_t           state_q, state_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] reload_q, reload_d;
  logic             tc_q, tc_d;

  // State and datapath registers; reset clears everything immediately.
  always_ff @(posedge ck or negedge nres) begin
    if (!nres) begin
      state_q  <= ST_IDLE;
      cnt_q    <= CNT_ZERO;
      reload_q <= CNT_ZERO;
      tc_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      reload_q <= reload_d;
      tc_q     <= tc_d;
    end
  end

  // Next state and count: load beats stop beats start beats counting.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    reload_d = reload_q;
    tc_d     = 1'b0;
    if (load) begin
      cnt_d    = din;
      reload_d = din;
      state_d  = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_RUN: begin
          if (stop) begin
            // Pause: q is kept so a later start resumes from here.
            state_d = ST_IDLE;
          end else if (en) begin
            if (cnt_q > CNT_ONE) begin
              cnt_d = cnt_q - CNT_ONE;
            end else if (cnt_q == CNT_ONE) begin
              tc_d = 1'b1;
              // A zero reload value would re-arm straight into a stuck zero count,
              // so it falls back to one-shot behaviour.
              if (auto_reload && (reload_q != CNT_ZERO)) begin
                cnt_d = reload_q;
              end else begin
                cnt_d   = CNT_ZERO;
                state_d = ST_DONE;
              end
            end else begin
              // RUN with a zero count is not reachable; park in DONE rather than wrap.
              state_d = ST_DONE;
            end
          end
        end
        ST_IDLE, ST_DONE: begin
          if (start) begin
            if (cnt_q != CNT_ZERO) begin
              state_d = ST_RUN;
            end else begin
              // Nothing left to count: expire on the spot.
              state_d = ST_DONE;
              tc_d    = 1'b1;
            end
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // Outputs decoded purely from registers, so no input reaches them combinationally.
  always_comb begin
    q    = cnt_q;
    tc   = tc_q;
    busy = (state_q == ST_RUN);
    done = (state_q == ST_DONE);
  end

endmodule
